// File: rtl/led_arbiter.sv
// Round-robin time-slot scheduler that shares one 4-bit LED decoder path between NUM_REQ requesters.
// Optional feature: define LED_ARB_IDLE_BLINK_EN to blink led_code between IDLE_CODE and 4'hF while idle.
module led_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] IDLE_CODE   = 4'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [3:0]             led_code,
  output logic                   busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [3:0]         led_q, led_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               found;
  logic [PTR_W-1:0]   pick_idx;
  logic               arbitrate;

  // ptr_q doubles as the current owner while in HOLD, so one search serves both
  // slot end (owner still requesting) and abort (owner's bit already low).
  always_comb begin
    int idx;
    found    = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    led_d     = led_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    arbitrate = 1'b0;

    if (state_q == S_IDLE) begin
      if (found) begin
        arbitrate = 1'b1;
      end else begin
`ifdef LED_ARB_IDLE_BLINK_EN
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          led_d = (led_q == IDLE_CODE) ? 4'hF : IDLE_CODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        cnt_d = '0;
        led_d = IDLE_CODE;
`endif
      end
    end else begin
      if (!req[ptr_q]) begin
        arbitrate = 1'b1;
      end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
        done_d    = gnt_q;
        arbitrate = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (arbitrate) begin
      cnt_d = '0;
      if (found) begin
        state_d         = S_HOLD;
        gnt_d           = '0;
        gnt_d[pick_idx] = 1'b1;
        ptr_d           = pick_idx;
        led_d           = data[4*pick_idx +: 4];
      end else begin
        state_d = S_IDLE;
        gnt_d   = '0;
        led_d   = IDLE_CODE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= IDLE_CODE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign led_code = led_q;
  assign busy     = (state_q == S_HOLD);

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Time-slot scheduler that shares the 4-bit LED decoder path between up to NUM_REQ requesters. Each requester raises `req` with a 4-bit code; the block grants one requester at a time in round-robin order, holds its latched code on `led_code` for HOLD_CYCLES clock cycles, then moves on. `led_code` feeds the `in` port of `led_decoder` directly.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- HOLD_CYCLES, 4: slot length in clock cycles, ≥1.
- IDLE_CODE, 4'h0: code driven on `led_code` when no slot is active.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  NUM_REQ  per-requester request, level.
- data  input  4*NUM_REQ  requester i code at [4i+3:4i].
- gnt  output  NUM_REQ  one-hot grant, registered.
- done  output  NUM_REQ  one-cycle pulse when requester i's slot completes in full.
- led_code  output  4  code to the decoder, registered.
- busy  output  1  high while in HOLD.

## Operation
- State and register updates on every rising `clk` edge.
- Reset (rst_n=0, async):
  - state=IDLE, gnt=0, done=0, busy=0.
  - led_code=IDLE_CODE, cnt=0.
  - last-grant pointer ptr=NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: gnt=0, busy=0. If any `req` bit is set, arbitrate and go to HOLD.
  - HOLD: exactly one `gnt` bit is set, busy=1, cnt counts 0..HOLD_CYCLES-1.
- Arbitration:
  - Search starts at index ptr+1 modulo NUM_REQ and picks the first set `req`.
  - On the grant edge: gnt←onehot(i), ptr←i, led_code←data[i] (latched; later data changes are ignored for that slot), cnt←0.
- Slot end, in the HOLD cycle where cnt==HOLD_CYCLES-1 and req[i] is still high:
  - done[i]=1 on the next edge, for one cycle.
  - If any `req` bit is set in that same cycle, re-arbitrate back-to-back and stay in HOLD; the same requester may win again if it is the only one requesting.
  - Otherwise go to IDLE, gnt←0, led_code←IDLE_CODE.
- Abort: req[i] low during any HOLD cycle ends the slot on the next edge.
  - No `done` pulse.
  - Arbitrate the remaining `req` bits as at slot end.
  - ptr still becomes i.
- Non-granted `req` changes during HOLD have no effect until the slot ends.
- cnt width is $clog2(HOLD_CYCLES+1); cnt never exceeds HOLD_CYCLES-1.
- Invariants checked by the bench:
  - `gnt` is zero or one-hot.
  - `done` is only set for the index granted in the previous cycle.

## Timing
- Request latency: req sampled high at edge k (state IDLE) → gnt and led_code valid after edge k, i.e. in the cycle after the request is seen.
- Slot length: gnt held for exactly HOLD_CYCLES cycles, with no gap between back-to-back slots.
- done[i] is asserted in the first cycle after the slot, coincident with the next grant or with IDLE.
- With HOLD_CYCLES=1, every cycle is a slot end and grants rotate each cycle.
- Reset asserted mid-slot drops all outputs to reset values immediately, with no `done` pulse. After release, the first grant goes to the lowest set index.

## Configuration
- LED_ARB_IDLE_BLINK_EN defined:
  - In IDLE, cnt free-runs 0..HOLD_CYCLES-1, and `led_code` toggles between IDLE_CODE and 4'hF each time cnt wraps.
  - The first IDLE value is IDLE_CODE, and cnt restarts at 0 on entry to IDLE.
  - A grant overrides the blink on the next edge.
- LED_ARB_IDLE_BLINK_EN undefined: `led_code` is constant IDLE_CODE in IDLE, and cnt is held at 0.

## Test plan
All scenarios use NUM_REQ=4, HOLD_CYCLES=4, IDLE_CODE=0, macro undefined unless stated.
- Single request: req=0001, data[3:0]=4'hA → gnt=0001 and led_code=A for 4 cycles, then done=0001 for one cycle, gnt=0, led_code=0.
- Contention: req=1111 held, codes 1,2,3,4 → grants 0,1,2,3,0… each 4 cycles, led_code 1,2,3,4,1…, no idle cycle between slots.
- Abort: req[2] dropped in the 2nd cycle of its slot while req[3]=1 → next edge gnt=1000, done stays 0, next search starts at index 3.
- Data change: data[0] changes mid-slot from 5 to 9 → led_code stays 5 for the whole slot; 9 appears only on the next grant to requester 0.
- Reset: rst_n pulled low mid-slot → outputs go to 0 asynchronously; after release with req=0110, requester 1 is granted first.
- Blink (macro defined, no req): led_code sequence 0×4, F×4, 0×4…; asserting req[0] switches to data[0] on the next edge.
